fetch_unit: RTL and testbench

Program-counter and fetch sequencer that consumes the jump/save interface driven by the control decoder. It holds the program counter, three PC save registers and a run/halt state machine. Each cycle it presents the fetch address to the instruction ROM. It sequences, branches or halts based on the decoder's jump strobes, save selects, the ALU equality flag and the decoder's done (Ack) strobe.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_pc_save_regs.sv | 58 +++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the fetch sequencer: run/halt state encoding and
// the PCRegSelect encodings used by the decoder to pick a PC save register.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] kPCNone = 2'b00;
    localparam logic [1:0] kPCReg1 = 2'b01;
    localparam logic [1:0] kPCReg2 = 2'b10;
    localparam logic [1:0] kPCReg3 = 2'b11;

endpackage

// File: rtl/fetch_unit_pc_save_regs.sv
// pc_save_regs
// Three-entry PC save register file, one write port, one combinational read
// port, both indexed by the decoder's PCRegSelect. Selector 00 addresses no
// entry: writes to it are dropped and reads return 0.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset, clears all entries
//   i_clr    synchronous clear of all entries (restart from HALT)
//   i_we     write enable
//   i_wsel   write select (01/10/11)
//   i_wdata  write data
//   i_rsel   read select (01/10/11)
//   o_rdata  combinational read data
module pc_save_regs
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    input  logic                i_we,
    input  logic [1:0]          i_wsel,
    input  logic [PC_WIDTH-1:0] i_wdata,
    input  logic [1:0]          i_rsel,
    output logic [PC_WIDTH-1:0] o_rdata
);

    logic [PC_WIDTH-1:0] r_reg1;
    logic [PC_WIDTH-1:0] r_reg2;
    logic [PC_WIDTH-1:0] r_reg3;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_reg1 <= '0;
            r_reg2 <= '0;
            r_reg3 <= '0;
        end else if (i_we) begin
            case (i_wsel)
                kPCReg1: r_reg1 <= i_wdata;
                kPCReg2: r_reg2 <= i_wdata;
                kPCReg3: r_reg3 <= i_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_rsel)
            kPCReg1: o_rdata = r_reg1;
            kPCReg2: o_rdata = r_reg2;
            kPCReg3: o_rdata = r_reg3;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Program counter and fetch sequencer. Holds the PC, three PC save registers
// and a run/halt FSM; sequences, branches or halts from decoder strobes.
// Optional feature macro: BRANCH_CTR_EN adds a saturating 16-bit count of
// taken jumps on output BranchCount.
// Ports:
//   Clk, Reset (sync, active-low), Start, Stall
//   JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect[1:0], Ack, Equal (decoder/ALU)
//   ProgCtr[PC_WIDTH-1:0] registered fetch address, Running, Done
//   BranchCount[15:0] (BRANCH_CTR_EN only)
//
// state | meaning
// IDLE  | out of reset, waiting for Start
// RUN   | fetching/executing, PC advances each unstalled cycle
// HALT  | Ack seen, PC holds the Ack address, waiting for Start
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH    = 10,
    parameter int SAVE_OFFSET = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Stall,
    input  logic                JumpEqual,
    input  logic                JumpNotEqual,
    input  logic                OffsetEn,
    input  logic [1:0]          PCRegSelect,
    input  logic                Ack,
    input  logic                Equal,
`ifdef BRANCH_CTR_EN
    output logic [15:0]         BranchCount,
`endif
    output logic [PC_WIDTH-1:0] ProgCtr,
    output logic                Running,
    output logic                Done
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [PC_WIDTH-1:0] w_save_data;
    logic [PC_WIDTH-1:0] w_jump_target;
    logic                w_sel_valid;
    logic                w_jump_taken;
    logic                w_save;
    logic                w_we;
    logic                w_restart;
    logic                w_branch;

    assign w_sel_valid  = (PCRegSelect != kPCNone);
    // Both strobes together is illegal from the decoder; resolve as unconditional.
    assign w_jump_taken = w_sel_valid &&
                          ((JumpEqual && Equal) || (JumpNotEqual && !Equal) ||
                           (JumpEqual && JumpNotEqual));
    assign w_save       = w_sel_valid && !JumpEqual && !JumpNotEqual;
    assign w_save_data  = OffsetEn ? (r_pc + PC_WIDTH'(SAVE_OFFSET)) : (r_pc + PC_WIDTH'(1));

    pc_save_regs #(
        .PC_WIDTH (PC_WIDTH)
    ) u_save_regs (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_clr   (w_restart),
        .i_we    (w_we),
        .i_wsel  (PCRegSelect),
        .i_wdata (w_save_data),
        .i_rsel  (PCRegSelect),
        .o_rdata (w_jump_target)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_we        = 1'b0;
        w_restart   = 1'b0;
        w_branch    = 1'b0;
        if (!Stall) begin
            case (r_state)
                IDLE, HALT: begin
                    if (Start) begin
                        w_state_nxt = RUN;
                        w_pc_nxt    = '0;
                        w_restart   = 1'b1;
                    end
                end
                RUN: begin
                    if (Ack) begin
                        w_state_nxt = HALT;
                    end else if (w_jump_taken) begin
                        w_pc_nxt = w_jump_target;
                        w_branch = 1'b1;
                    end else begin
                        w_we     = w_save;
                        w_pc_nxt = r_pc + PC_WIDTH'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef BRANCH_CTR_EN
    logic [15:0] r_branch_ctr;

    always_ff @(posedge Clk) begin
        if (!Reset || w_restart) begin
            r_branch_ctr <= '0;
        end else if (w_branch && (r_branch_ctr != 16'hFFFF)) begin
            r_branch_ctr <= r_branch_ctr + 16'd1;
        end
    end

    assign BranchCount = r_branch_ctr;
`endif

    assign ProgCtr = r_pc;
    assign Running = (r_state == RUN);
    assign Done    = (r_state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset, Start, Stall, JumpEqual, JumpNotEqual, OffsetEn, Ack, Equal;
    logic [1:0] PCRegSelect;
    logic [9:0] ProgCtr;
    logic       Running, Done;

    logic       r4_reset, r4_start, r4_je, r4_off, r4_eq;
    logic [1:0] r4_sel;
    logic [3:0] pc4;
    logic       run4, done4;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BRANCH_CTR_EN
    logic [15:0] BranchCount;
    logic [15:0] bc4;
`endif

    always #5 Clk = ~Clk;

    fetch_unit #(.PC_WIDTH(10), .SAVE_OFFSET(2)) u_dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Stall        (Stall),
        .JumpEqual    (JumpEqual),
        .JumpNotEqual (JumpNotEqual),
        .OffsetEn     (OffsetEn),
        .PCRegSelect  (PCRegSelect),
        .Ack          (Ack),
        .Equal        (Equal),
`ifdef BRANCH_CTR_EN
        .BranchCount  (BranchCount),
`endif
        .ProgCtr      (ProgCtr),
        .Running      (Running),
        .Done         (Done)
    );

    fetch_unit #(.PC_WIDTH(4), .SAVE_OFFSET(2)) u_dut4 (
        .Clk          (Clk),
        .Reset        (r4_reset),
        .Start        (r4_start),
        .Stall        (1'b0),
        .JumpEqual    (r4_je),
        .JumpNotEqual (1'b0),
        .OffsetEn     (r4_off),
        .PCRegSelect  (r4_sel),
        .Ack          (1'b0),
        .Equal        (r4_eq),
`ifdef BRANCH_CTR_EN
        .BranchCount  (bc4),
`endif
        .ProgCtr      (pc4),
        .Running      (run4),
        .Done         (done4)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic dec(input logic je, input logic jne, input logic off,
                       input logic [1:0] sel, input logic ack, input logic eq);
        JumpEqual    = je;
        JumpNotEqual = jne;
        OffsetEn     = off;
        PCRegSelect  = sel;
        Ack          = ack;
        Equal        = eq;
    endtask

    task automatic chk_main(input string tag, input int pc, input logic run, input logic done);
        check({tag, "_pc"},   16'(ProgCtr), 16'(pc));
        check({tag, "_run"},  16'(Running), 16'(run));
        check({tag, "_done"}, 16'(Done),    16'(done));
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0;
        dec(0, 0, 0, 2'b00, 0, 0);
        r4_reset = 1'b0; r4_start = 1'b0; r4_je = 1'b0; r4_off = 1'b0; r4_eq = 1'b0; r4_sel = 2'b00;
        tick(); tick();
        chk_main("reset", 0, 0, 0);
`ifdef BRANCH_CTR_EN
        check("reset_bc", BranchCount, 16'd0);
`endif
        Reset = 1'b1; r4_reset = 1'b1;
        tick();
        chk_main("idle_hold", 0, 0, 0);

        Start = 1'b1; tick(); Start = 1'b0;
        chk_main("start", 0, 1, 0);
        tick(); check("seq1", 16'(ProgCtr), 16'd1);
        tick(); check("seq2", 16'(ProgCtr), 16'd2);
        tick(); check("seq3", 16'(ProgCtr), 16'd3);

        // PC=3: save PC+2 into reg2 -> 5
        dec(0, 0, 1, 2'b10, 0, 0); tick();
        check("save_off", 16'(ProgCtr), 16'd4);
        // jne with Equal=1 is not taken, no save
        dec(0, 1, 0, 2'b10, 0, 1); tick();
        check("jne_not_taken", 16'(ProgCtr), 16'd5);
        // PC=5: save PC+1 into reg1 -> 6
        dec(0, 0, 0, 2'b01, 0, 0); tick();
        check("save_plain", 16'(ProgCtr), 16'd6);
        dec(0, 0, 0, 2'b00, 0, 0); tick();
        check("seq7", 16'(ProgCtr), 16'd7);

        // stall three cycles with Start/Ack asserted: nothing moves
        Stall = 1'b1; Start = 1'b1; Ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_main("stall", 7, 1, 0);
        end
        Stall = 1'b0; Start = 1'b0; Ack = 1'b0;
        tick(); tick();
        check("seq9", 16'(ProgCtr), 16'd9);

        dec(1, 0, 0, 2'b01, 0, 1); tick();
        check("je_taken_reg1", 16'(ProgCtr), 16'd6);
        dec(1, 0, 0, 2'b10, 0, 1); tick();
        check("je_taken_reg2", 16'(ProgCtr), 16'd5);
        // PC=5: save PC+2 into reg3 -> 7, then jump through it immediately
        dec(0, 0, 1, 2'b11, 0, 0); tick();
        check("save_reg3", 16'(ProgCtr), 16'd6);
        dec(1, 1, 0, 2'b11, 0, 0); tick();
        check("both_strobes_taken", 16'(ProgCtr), 16'd7);
        dec(1, 0, 0, 2'b00, 0, 1); tick();
        check("jump_sel00_noop", 16'(ProgCtr), 16'd8);
        dec(0, 0, 0, 2'b00, 0, 0);
        tick(); tick(); tick(); tick();
        check("seq12", 16'(ProgCtr), 16'd12);

        // Ack outranks a taken jump
        dec(1, 0, 0, 2'b01, 1, 1); tick();
        chk_main("ack_halt", 12, 0, 1);
        dec(1, 0, 0, 2'b01, 0, 1); tick();
        chk_main("halt_ignores", 12, 0, 1);
`ifdef BRANCH_CTR_EN
        check("bc_three", BranchCount, 16'd3);
`endif
        dec(0, 0, 0, 2'b00, 0, 0);
        Start = 1'b1; tick(); Start = 1'b0;
        chk_main("restart", 0, 1, 0);
`ifdef BRANCH_CTR_EN
        check("bc_restart_clr", BranchCount, 16'd0);
`endif
        // all save registers must read back as 0 after the restart
        for (int s = 1; s <= 3; s++) begin
            dec(1, 0, 0, 2'(s), 0, 1); tick();
            check("restart_reg_clr", 16'(ProgCtr), 16'd0);
        end
`ifdef BRANCH_CTR_EN
        check("bc_after_clr_jumps", BranchCount, 16'd3);
`endif
        dec(0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        check("seq20", 16'(ProgCtr), 16'd20);

        // reset mid-run with a reg3 save pending
        dec(0, 0, 0, 2'b11, 0, 0);
        Reset = 1'b0; tick(); Reset = 1'b1;
        chk_main("midrun_reset", 0, 0, 0);
`ifdef BRANCH_CTR_EN
        check("bc_reset_clr", BranchCount, 16'd0);
`endif
        dec(0, 0, 0, 2'b00, 0, 0);
        Start = 1'b1; tick(); Start = 1'b0;
        dec(1, 0, 0, 2'b11, 0, 1); tick();
        check("reg3_cleared", 16'(ProgCtr), 16'd0);
        dec(0, 0, 0, 2'b00, 0, 0);

        // 4-bit PC: wrap of both the PC and a saved value
        r4_start = 1'b1; tick(); r4_start = 1'b0;
        check("w4_start", 16'(pc4), 16'd0);
        check("w4_run", 16'(run4), 16'd1);
        for (int i = 0; i < 15; i++) tick();
        check("w4_pc15", 16'(pc4), 16'd15);
        r4_sel = 2'b01; r4_off = 1'b1; tick();
        check("w4_wrap", 16'(pc4), 16'd0);
        r4_off = 1'b0; r4_je = 1'b1; r4_eq = 1'b1; tick();
        check("w4_saved_wrap", 16'(pc4), 16'd1);
        r4_je = 1'b0; r4_eq = 1'b0; r4_sel = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
